// File: rtl/bus_grant_scheduler.sv
// Round-robin bus grant scheduler.
// Grants one of NUM_SRC bus sources at a time and registers a one-hot select
// word for the 32-to-5 bus encoder, together with the matching 5-bit index.
// Each tenure is capped at MAX_HOLD cycles. Every release is followed by one
// idle (GAP) cycle, so the encoder never sees two owners back to back.
module bus_grant_scheduler #(
   parameter int NUM_SRC  = 24,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic               clock,
   input  logic               clear,
   input  logic [NUM_SRC-1:0] req,
   input  logic [NUM_SRC-1:0] src_en,
   output logic [31:0]        grant,
   output logic [4:0]         grant_idx,
   output logic               bus_busy,
   output logic               timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [4:0]       LAST_SRC  = 5'(NUM_SRC - 1);
   localparam logic [4:0]       NO_GRANT  = 5'd31;

   state_t             state;
   state_t             state_nxt;
   logic [4:0]         rr_ptr;
   logic [4:0]         rr_ptr_nxt;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   hold_cnt_nxt;
   logic [31:0]        grant_nxt;
   logic [4:0]         idx_nxt;
   logic               busy_nxt;
   logic               timeout_nxt;

   logic [NUM_SRC-1:0] elig;
   logic               any_elig;
   logic               owner_elig;
   logic               hold_limit;
   logic               release_own;
   logic               found_hi;
   logic [4:0]         win_hi;
   logic [4:0]         win_lo;
   logic [4:0]         winner;

   assign elig        = req & src_en;
   assign any_elig    = |elig;
   // The current owner is the single set bit of the registered grant word.
   assign owner_elig  = |(elig & grant[NUM_SRC-1:0]);
   assign hold_limit  = (hold_cnt == HOLD_LAST);
   assign release_own = !owner_elig || hold_limit;

   // Round-robin search: lowest eligible index at or above rr_ptr, otherwise wrap to the lowest eligible index.
   always_comb begin
      found_hi = 1'b0;
      win_hi   = 5'd0;
      win_lo   = 5'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_lo = 5'(i);
            if (5'(i) >= rr_ptr) begin
               win_hi   = 5'(i);
               found_hi = 1'b1;
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   // State register and registered outputs; clear drops the grant at once, with no GAP cycle.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         rr_ptr    <= 5'd0;
         hold_cnt  <= '0;
         grant     <= 32'd0;
         grant_idx <= NO_GRANT;
         bus_busy  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         hold_cnt  <= hold_cnt_nxt;
         grant     <= grant_nxt;
         grant_idx <= idx_nxt;
         bus_busy  <= busy_nxt;
         timeout   <= timeout_nxt;
      end
   end

   // Next-state logic: IDLE and GAP arbitrate, OWN holds until the owner drops out or the tenure cap is hit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_elig) state_nxt = OWN;
         OWN:     if (release_own) state_nxt = GAP;
         GAP:     state_nxt = any_elig ? OWN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of grant, index, pointer and tenure counter for each state.
   always_comb begin
      grant_nxt    = grant;
      idx_nxt      = grant_idx;
      busy_nxt     = bus_busy;
      timeout_nxt  = 1'b0;
      rr_ptr_nxt   = rr_ptr;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE, GAP: begin
            if (any_elig) begin
               grant_nxt    = 32'd1 << winner;
               idx_nxt      = winner;
               busy_nxt     = 1'b1;
               hold_cnt_nxt = '0;
            end else begin
               grant_nxt = 32'd0;
               idx_nxt   = NO_GRANT;
               busy_nxt  = 1'b0;
            end
         end
         OWN: begin
            if (release_own) begin
               grant_nxt   = 32'd0;
               idx_nxt     = NO_GRANT;
               busy_nxt    = 1'b0;
               // A timeout is reported only when the owner still wanted the bus.
               timeout_nxt = owner_elig;
               rr_ptr_nxt  = (grant_idx == LAST_SRC) ? 5'd0 : grant_idx + 5'd1;
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            grant_nxt = 32'd0;
            idx_nxt   = NO_GRANT;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Directed bench for bus_grant_scheduler with hand-computed expectations.
module tb_bus_grant_scheduler;

   logic        clock;
   logic        clear;
   logic [23:0] req;
   logic [23:0] src_en;
   logic [31:0] grant;
   logic [4:0]  grant_idx;
   logic        bus_busy;
   logic        timeout;

   int n_chk = 0;
   int n_err = 0;

   bus_grant_scheduler #(
      .NUM_SRC  (24),
      .MAX_HOLD (16),
      .CNT_W    (5)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .req       (req),
      .src_en    (src_en),
      .grant     (grant),
      .grant_idx (grant_idx),
      .bus_busy  (bus_busy),
      .timeout   (timeout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear = 1'b1;
      #2;
      clear = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, grant, 32'd0);
      chk({tag, "_idx"}, 32'(grant_idx), 32'd31);
      chk({tag, "_busy"}, 32'(bus_busy), 32'd0);
   endtask

   // Two-cycle tenure of src, then it drops req for the GAP and raises it again.
   task automatic rr_tenure(input int src);
      tick();
      chk("rr_grant", grant, 32'd1 << src);
      chk("rr_idx", 32'(grant_idx), 32'(src));
      tick();
      chk("rr_hold", grant, 32'd1 << src);
      req[src] = 1'b0;
      tick();
      chk("rr_gap", grant, 32'd0);
      chk("rr_onehot", 32'($onehot0(grant)), 32'd1);
      req[src] = 1'b1;
   endtask

   initial begin
      req    = 24'd0;
      src_en = 24'hFFFFFF;
      clear  = 1'b0;
      #2 clear = 1'b1;
      #1;
      chk_idle("rst");
      chk("rst_timeout", 32'(timeout), 32'd0);
      @(posedge clock);
      #1;
      clear = 1'b0;

      // Single request, release, GAP, stay idle
      req = 24'h000010;
      tick();
      chk("single_grant", grant, 32'h00000010);
      chk("single_idx", 32'(grant_idx), 32'd4);
      chk("single_busy", 32'(bus_busy), 32'd1);
      req = 24'd0;
      tick();
      chk_idle("single_gap");
      tick();
      chk_idle("single_idle");

      // Asynchronous clear in the middle of a tenure
      req = 24'd1 << 5;
      tick();
      chk("own5_grant", grant, 32'h00000020);
      tick();
      chk("own5_hold", grant, 32'h00000020);
      #2 clear = 1'b1;
      #1;
      chk_idle("async_clr");
      #1 clear = 1'b0;
      tick();
      chk("after_clr_grant", grant, 32'h00000020);
      chk("after_clr_idx", 32'(grant_idx), 32'd5);
      req = 24'd0;
      tick();
      tick();

      // Round-robin among 3, 7, 20
      do_reset();
      req = (24'd1 << 3) | (24'd1 << 7) | (24'd1 << 20);
      rr_tenure(3);
      rr_tenure(7);
      rr_tenure(20);
      tick();
      chk("rr_wrap_grant", grant, 32'h00000008);
      chk("rr_wrap_idx", 32'(grant_idx), 32'd3);
      req = 24'd0;
      tick();
      tick();

      // Tenure cap with a single continuous requester
      do_reset();
      req = 24'd1 << 9;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("to_own_idx", 32'(grant_idx), 32'd9);
         chk("to_own_timeout", 32'(timeout), 32'd0);
      end
      tick();
      chk_idle("to_gap");
      chk("to_pulse", 32'(timeout), 32'd1);
      tick();
      chk("to_regrant_idx", 32'(grant_idx), 32'd9);
      chk("to_pulse_end", 32'(timeout), 32'd0);

      // Second tenure of 9 with 2 waiting: 2 follows the GAP
      req[2] = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      chk("to2_last_idx", 32'(grant_idx), 32'd9);
      tick();
      chk("to2_gap_grant", grant, 32'd0);
      chk("to2_pulse", 32'(timeout), 32'd1);
      tick();
      chk("to2_next_idx", 32'(grant_idx), 32'd2);
      chk("to2_next_grant", grant, 32'h00000004);

      // Drop on the cap cycle: counts as a normal release, no timeout
      req[9] = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("both_last_idx", 32'(grant_idx), 32'd2);
      req = 24'd0;
      tick();
      chk_idle("both_gap");
      chk("both_no_timeout", 32'(timeout), 32'd0);
      tick();

      // Mask release at the top source, pointer wraps to 0
      do_reset();
      req = 24'd1 << 23;
      tick();
      chk("mask_own_idx", 32'(grant_idx), 32'd23);
      chk("mask_own_grant", grant, 32'h00800000);
      src_en[23] = 1'b0;
      tick();
      chk_idle("mask_gap");
      src_en = 24'hFFFFFF;
      req = (24'd1 << 0) | (24'd1 << 22);
      tick();
      chk("wrap_first_idx", 32'(grant_idx), 32'd0);
      req[0] = 1'b0;
      tick();
      chk("wrap_gap", grant, 32'd0);
      tick();
      chk("wrap_second_idx", 32'(grant_idx), 32'd22);
      chk("wrap_second_grant", grant, 32'h00400000);
      req = 24'd0;
      tick();
      tick();
      chk_idle("final_idle");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
